// File: rtl/uart_frame_streamer_pkg.sv
// rtl/uart_frame_streamer_pkg.sv - shared state encoding, header bytes and guard margin for the frame streamer
package uart_frame_streamer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_RD,
    S_RDW,
    S_SEND,
    S_WSENT,
    S_GUARD,
    S_CSUM,
    S_FIN
  } state_t;

  // Which kind of byte is currently in flight; decides where GUARD routes next.
  typedef enum logic [1:0] {
    PH_HDR,
    PH_PAY,
    PH_CSUM
  } phase_t;

  localparam logic [7:0] HDR_DEF0 = 8'hFF;
  localparam logic [7:0] HDR_DEF1 = 8'h00;
  localparam logic [7:0] HDR_DEF2 = 8'hFF;
  localparam logic [7:0] HDR_DEF3 = 8'hA5;

  // Extra cycles after byte_sent: stop bit plus UART return to idle.
  localparam int GUARD_MARGIN = 2;

  function automatic logic [7:0] hdr_pick(input logic [1:0] idx, input logic [31:0] hdrs);
    return hdrs[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// rtl/uart_gap_timer.sv - loadable down-counter with zero flag for inter-byte guard time
module uart_gap_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/uart_frame_streamer.sv
// rtl/uart_frame_streamer.sv - streams sync header, frame-buffer payload and checksum to a byte UART
module uart_frame_streamer
  import uart_frame_streamer_pkg::*;
#(
  parameter int         ADDR_W      = 17,
  parameter int         FRAME_BYTES = 76800,
  parameter int         BIT_CYCLES  = 434,
  parameter logic [7:0] HDR0        = HDR_DEF0,
  parameter logic [7:0] HDR1        = HDR_DEF1,
  parameter logic [7:0] HDR2        = HDR_DEF2,
  parameter logic [7:0] HDR3        = HDR_DEF3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_go,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_byte_sent,
  output logic              busy,
  output logic              frame_done,
  output logic              aborted,
  output logic [7:0]        checksum
);

  localparam int              GUARD_LOAD_I = BIT_CYCLES + GUARD_MARGIN;
  localparam int              GW           = $clog2(GUARD_LOAD_I + 1);
  localparam logic [GW-1:0]   GUARD_LOAD   = GW'(GUARD_LOAD_I);
  localparam logic [ADDR_W:0] PAY_TOTAL    = (ADDR_W + 1)'(FRAME_BYTES);
  localparam logic [31:0]     HDR_WORD     = {HDR3, HDR2, HDR1, HDR0};

  state_t          state, state_nx;
  phase_t          phase;
  logic [1:0]      hdr_idx;
  logic [ADDR_W:0] pay_cnt;
  logic            guard_load;
  logic            guard_zero;

  assign guard_load = (state == S_WSENT) && tx_byte_sent;

  uart_gap_timer #(.W(GW)) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (guard_load),
    .load_val (GUARD_LOAD),
    .zero     (guard_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    tx_start   = 1'b0;
    mem_rd_en  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (frame_go) state_nx = S_HDR;
      end
      S_HDR: begin
        tx_start = 1'b1;
        state_nx = S_WSENT;
      end
      S_RD: begin
        mem_rd_en = 1'b1;
        state_nx  = S_RDW;
      end
      S_RDW: begin
        state_nx = S_SEND;
      end
      S_SEND: begin
        tx_start = 1'b1;
        state_nx = S_WSENT;
      end
      S_WSENT: begin
        if (tx_byte_sent) state_nx = S_GUARD;
      end
      S_GUARD: begin
        // Abort is only honoured here so a byte is never cut mid-flight.
        if (guard_zero) begin
          if (abort) begin
            state_nx = S_FIN;
          end else begin
            case (phase)
              PH_HDR:  state_nx = (hdr_idx == 2'd3) ? S_RD : S_HDR;
              PH_PAY:  state_nx = (pay_cnt == PAY_TOTAL) ? S_CSUM : S_RD;
              default: state_nx = S_FIN;
            endcase
          end
        end
      end
      S_CSUM: begin
        tx_start = 1'b1;
        state_nx = S_WSENT;
      end
      S_FIN: begin
        frame_done = 1'b1;
        busy       = 1'b0;
        state_nx   = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= PH_HDR;
      hdr_idx  <= 2'd0;
      pay_cnt  <= '0;
      mem_addr <= '0;
      tx_data  <= 8'h00;
      checksum <= 8'h00;
      aborted  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_go) begin
            phase    <= PH_HDR;
            hdr_idx  <= 2'd0;
            pay_cnt  <= '0;
            mem_addr <= '0;
            checksum <= 8'h00;
            aborted  <= 1'b0;
            tx_data  <= hdr_pick(2'd0, HDR_WORD);
          end
        end
        S_RDW: begin
          tx_data  <= mem_rd_data;
          checksum <= checksum + mem_rd_data;
          pay_cnt  <= pay_cnt + (ADDR_W + 1)'(1);
          phase    <= PH_PAY;
        end
        S_GUARD: begin
          if (guard_zero) begin
            if (abort) begin
              aborted <= 1'b1;
            end else begin
              case (state_nx)
                S_HDR: begin
                  hdr_idx <= hdr_idx + 2'd1;
                  tx_data <= hdr_pick(hdr_idx + 2'd1, HDR_WORD);
                end
                S_RD: begin
                  // First payload read follows the header at address 0.
                  if (phase == PH_PAY) mem_addr <= mem_addr + ADDR_W'(1);
                end
                S_CSUM: begin
                  tx_data <= checksum;
                  phase   <= PH_CSUM;
                end
                default: ;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_frame_streamer.md
Name: uart_frame_streamer

Overview:
- Sequencer that dumps a captured camera frame from the frame buffer over the UART transmitter, one byte at a time.
- Each frame is sent as a 4-byte sync header, then FRAME_BYTES payload bytes read from buffer RAM, then a 1-byte checksum.
- Sits between the frame-buffer read port and the byte-level UART TX (start_tx / in_data / byte_sent handshake) and owns all pacing of that transmitter.

Parameters:
- ADDR_W, 17, frame-buffer address width.
- FRAME_BYTES, 76800, payload bytes per frame (must be ≤ 2**ADDR_W, ≥ 1).
- BIT_CYCLES, 434, clk cycles per UART bit (matches the baud tick generator).
- HDR0..HDR3, 8'hFF 8'h00 8'hFF 8'hA5, sync header bytes in send order.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- frame_go  in  1  one-cycle pulse; start a frame dump (ignored unless idle)
- abort  in  1  level; terminate the current dump cleanly
- mem_addr  out  ADDR_W  frame-buffer read address
- mem_rd_en  out  1  read strobe; data valid on mem_rd_data exactly 1 cycle later
- mem_rd_data  in  8  frame-buffer read data
- tx_data  out  8  byte to the UART (in_data)
- tx_start  out  1  one-cycle start pulse to the UART (start_tx)
- tx_byte_sent  in  1  UART byte_sent pulse (asserted at entry to stop bit)
- busy  out  1  high from frame_go acceptance until return to IDLE
- frame_done  out  1  one-cycle pulse when checksum byte fully sent or abort completes
- aborted  out  1  sticky flag; set when a dump ends by abort, cleared on next accepted frame_go
- checksum  out  8  running mod-256 sum of payload bytes sent in current/last frame

Behaviour:
- Reset: state IDLE; all outputs 0 (tx_data 0, mem_addr 0, checksum 0, aborted 0). Reset mid-frame abandons the dump immediately; the UART is reset by the same signal.
- States: IDLE, HDR, RD, RDW, SEND, WSENT, GUARD, CSUM, FIN.
- IDLE: on frame_go → HDR; clear hdr_idx, mem_addr, checksum, aborted; busy=1 from next cycle.
- HDR: tx_data=HDRn[hdr_idx]; pulse tx_start 1 cycle → WSENT.
- RD: mem_rd_en=1 one cycle at mem_addr → RDW. RDW: capture mem_rd_data into tx_data, checksum += byte (8-bit wrap) → SEND.
- SEND: pulse tx_start → WSENT.
- WSENT: wait for tx_byte_sent; no timeout. On pulse → GUARD, load guard counter with BIT_CYCLES+2 (covers stop bit + UART return to IDLE).
- GUARD: count down to 0, then route: header not finished → HDR (hdr_idx+1); header done or payload remaining → RD (mem_addr+1 after each payload byte, first payload at address 0); payload count reached FRAME_BYTES → CSUM; checksum byte just sent → FIN.
- CSUM: tx_data=checksum; pulse tx_start → WSENT.
- FIN: pulse frame_done, busy=0 → IDLE.
- tx_start is never asserted outside HDR/SEND/CSUM; at most one tx_start per tx_byte_sent; minimum start-to-start spacing is therefore one full UART frame + guard.
- abort: sampled only in GUARD at count 0 (never cuts a byte mid-flight); if high → set aborted, go FIN (frame_done pulses, no checksum byte sent). Abort asserted in IDLE has no effect.
- frame_go while busy: ignored, not queued.
- frame_go and abort in same cycle in IDLE: frame accepted; abort evaluated at first GUARD.
- Counters: payload counter ADDR_W+1 bits to avoid wrap at FRAME_BYTES = 2**ADDR_W; mem_addr never exceeds FRAME_BYTES-1.
- Spurious tx_byte_sent outside WSENT: ignored.

Decomposition:
- Shared package: state encoding, header byte constants, guard-margin constant (2).
- One sub-module: uart_gap_timer (loadable down-counter with zero flag) used by GUARD; all else in the top FSM.

Test Plan:
- FRAME_BYTES=4, BIT_CYCLES=4, RAM={10,20,30,F0}, UART model answering each tx_start with byte_sent after 36 cycles → byte stream FF 00 FF A5 10 20 30 F0 50, checksum=8'h50, one frame_done, aborted=0.
- Checksum wrap: RAM={FF,FF,02,00} → final byte 8'h00.
- Pacing: measure tx_start-to-next-tx_start ≥ byte_sent delay + BIT_CYCLES+2 cycles; no tx_start while in WSENT.
- abort raised during payload byte 2 → byte 2 completes, no further bytes, no checksum byte, frame_done pulses, aborted=1; next frame_go clears aborted.
- frame_go pulsed again mid-frame → ignored, exactly 9 bytes sent; reset asserted mid-byte → all outputs 0 next cycle, IDLE.
- Read latency: mem_rd_en single-cycle pulses at addresses 0,1,2,3 in order; tx_data equals RAM[addr] captured one cycle later.
